// File: rtl/rbuf_avg.sv
`default_nettype none
// ============================================================================
//  Module      : rbuf_avg
//  Description : Reads the M-word rbuf ring back on each done trigger and
//                emits the truncated moving average of the ring contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module rbuf_avg #(
    parameter int M         = 4,
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 12,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done_i,
    output logic [ADDR_SIZE-1:0] rd_addr,
    input  logic [DATA_SIZE-1:0] rd_data,
    output logic [DATA_SIZE-1:0] avg,
    output logic                 avg_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int LOG2M  = $clog2(M);
    localparam int ACC_W  = DATA_SIZE + LOG2M;
    localparam int FILL_W = $clog2(M + 1);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(M - 1);
    localparam logic [FILL_W-1:0]    FILL_MAX  = FILL_W'(M);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [DATA_SIZE-1:0] avg_q, avg_d;
    logic                 vld_q, vld_d;
    logic                 busy_q, busy_d;
    logic                 ovr_q, ovr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 pend_q, pend_d;
    logic                 done_q;
    logic                 rdv_q;

    logic w_trig;
    logic w_cap;
    logic w_start;

    assign w_trig = done_i & ~done_q;
    // rdv_q marks that an address was issued one cycle ago (2-cycle BRAM path)
    assign w_cap  = (RD_LAT == 1) ? (state_q == S_READ) : rdv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            acc_q   <= '0;
            avg_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            fill_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            avg_q   <= avg_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            done_q  <= done_i;
            rdv_q   <= (state_q == S_READ);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = w_cap ? (acc_q + ACC_W'(rd_data)) : acc_q;
        avg_d   = avg_q;
        vld_d   = 1'b0;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        fill_d  = fill_q;
        pend_d  = pend_q;
        w_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_trig) begin
                    w_start = 1'b1;
                end
            end
            S_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!w_cap) begin
                    state_d = S_OUT;
                    avg_d   = acc_q[ACC_W-1:LOG2M];
                    vld_d   = (fill_q == FILL_MAX);
                    busy_d  = 1'b0;
                end
            end
            S_OUT: begin
                if (pend_q || w_trig) begin
                    w_start = 1'b1;
                    // a fresh trigger arriving alongside the pending one is kept
                    pend_d  = pend_q & w_trig;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_READ || state_q == S_DRAIN) && w_trig) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        if (w_start) begin
            state_d = S_READ;
            addr_d  = '0;
            acc_d   = '0;
            busy_d  = 1'b1;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    assign rd_addr   = addr_q;
    assign avg       = avg_q;
    assign avg_valid = vld_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_rbuf_avg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rbuf_avg
//  Description : Directed bench for rbuf_avg at RD_LAT=1 and RD_LAT=2 against
//                a timing-level model of the averaging passes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rbuf_avg;

    localparam int M  = 4;
    localparam int AW = 5;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic done_i = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:31];

    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] rdata1, rdata2, avg1, avg2;
    logic          vld1, vld2, busy1, busy2, ovr1, ovr2;

    assign rdata1 = mem[addr1];
    always @(posedge clk) rdata2 <= mem[addr2];

    rbuf_avg #(.M(M), .ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .done_i(done_i), .rd_addr(addr1), .rd_data(rdata1),
        .avg(avg1), .avg_valid(vld1), .busy(busy1), .overrun(ovr1)
    );

    rbuf_avg #(.M(M), .ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .done_i(done_i), .rd_addr(addr2), .rd_data(rdata2),
        .avg(avg2), .avg_valid(vld2), .busy(busy2), .overrun(ovr2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: each pass is described by its start edge S; everything else
    // follows from S, M and the read latency L of each instance.
    int      cyc = 0;
    bit      act  [2];
    int      ps   [2];
    bit      pend [2];
    int      fill [2];
    bit      movr [2];
    int      sum  [2];
    bit      ebusy[2];
    bit      evld [2];
    int      eaddr[2];
    int      eavg [2];
    bit      dprev;
    bit      trig;
    bit      npend;
    int      edg;

    task automatic start_pass(input int d);
        act[d]  = 1'b1;
        ps[d]   = cyc;
        fill[d] = (fill[d] < M) ? fill[d] + 1 : M;
        sum[d]  = 0;
        for (int i = 0; i < M; i++) sum[d] += int'(mem[i]);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            dprev = 1'b0;
            for (int d = 0; d < 2; d++) begin
                act[d] = 0; pend[d] = 0; fill[d] = 0; movr[d] = 0;
                ebusy[d] = 0; evld[d] = 0; eaddr[d] = 0; eavg[d] = 0;
            end
        end else begin
            trig  = done_i && !dprev;
            dprev = done_i;
            for (int d = 0; d < 2; d++) begin
                edg = ps[d] + M + d + 1;
                if (act[d] && cyc == edg + 1) begin
                    act[d] = 1'b0;
                    if (pend[d] || trig) begin
                        npend = pend[d] && trig;
                        start_pass(d);
                        pend[d] = npend;
                    end
                end else if (!act[d]) begin
                    if (trig) start_pass(d);
                end else if (trig) begin
                    if (pend[d]) movr[d] = 1'b1;
                    else         pend[d] = 1'b1;
                end
                edg      = ps[d] + M + d + 1;
                ebusy[d] = act[d] && (cyc < edg);
                eaddr[d] = (act[d] && (cyc - ps[d] < M)) ? cyc - ps[d] : 0;
                evld[d]  = act[d] && (cyc == edg) && (fill[d] == M);
                if (act[d] && cyc == edg) eavg[d] = sum[d] >> $clog2(M);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("addr1",  int'(addr1), eaddr[0]);
        chk("busy1",  int'(busy1), int'(ebusy[0]));
        chk("valid1", int'(vld1),  int'(evld[0]));
        chk("avg1",   int'(avg1),  eavg[0]);
        chk("ovr1",   int'(ovr1),  int'(movr[0]));
        chk("addr2",  int'(addr2), eaddr[1]);
        chk("busy2",  int'(busy2), int'(ebusy[1]));
        chk("valid2", int'(vld2),  int'(evld[1]));
        chk("avg2",   int'(avg2),  eavg[1]);
        chk("ovr2",   int'(ovr2),  int'(movr[1]));
    end

    int vcnt1 = 0, vcnt2 = 0, bcnt1 = 0;
    always @(posedge clk) begin
        #1;
        if (vld1)  vcnt1++;
        if (vld2)  vcnt2++;
        if (busy1) bcnt1++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        @(negedge clk) done_i = 1'b1;
        @(negedge clk) done_i = 1'b0;
    endtask

    task automatic load(input int a, input int b, input int c, input int e);
        mem[0] = DW'(a); mem[1] = DW'(b); mem[2] = DW'(c); mem[3] = DW'(e);
    endtask

    int v0, v2, b0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        idle(3);
        rst = 1'b1;
        chk("reset_avg", int'(avg1), 0);
        chk("reset_busy", int'(busy1), 0);

        // warm-up: only the 4th trigger produces a pulse
        load(100, 200, 300, 400);
        for (int p = 0; p < 3; p++) begin
            pulse();
            idle(19);
        end
        chk("warm_no_pulse", vcnt1, 0);
        pulse();
        repeat (4) @(posedge clk);
        #1 chk("lat_e4_valid1", int'(vld1), 0);
        @(posedge clk);
        #1 chk("lat_e5_valid1", int'(vld1), 1);
        chk("lat_e5_avg1", int'(avg1), 250);
        @(posedge clk);
        #1 chk("lat_e6_valid2", int'(vld2), 1);
        chk("lat_e6_avg2", int'(avg2), 250);
        idle(10);
        chk("warm_one_pulse", vcnt1, 1);

        load(4095, 4095, 4095, 4095);
        pulse();
        idle(10);
        chk("max_avg1", int'(avg1), 4095);
        chk("max_avg2", int'(avg2), 4095);

        load(1, 2, 2, 2);
        pulse();
        idle(10);
        chk("trunc_avg1", int'(avg1), 1);

        load(8, 8, 8, 8);
        pulse();
        repeat (6) @(posedge clk);
        #1 chk("lat2_valid2", int'(vld2), 1);
        chk("lat2_avg2", int'(avg2), 8);
        chk("lat2_valid1_gone", int'(vld1), 0);
        idle(10);

        // level held high: one pass only
        v0 = vcnt1;
        b0 = bcnt1;
        @(negedge clk) done_i = 1'b1;
        @(posedge clk);
        #1 chk("seq_addr0", int'(addr1), 0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1 chk("seq_addr", int'(addr1), k);
        end
        repeat (7) @(negedge clk);
        done_i = 1'b0;
        idle(10);
        chk("held_busy_cycles", bcnt1 - b0, 5);
        chk("held_one_pulse", vcnt1 - v0, 1);

        // trigger at E0+2: one pending pass
        v0 = vcnt1;
        v2 = vcnt2;
        pulse();
        pulse();
        idle(25);
        chk("pend_pulses1", vcnt1 - v0, 2);
        chk("pend_pulses2", vcnt2 - v2, 2);
        chk("pend_no_ovr", int'(ovr1), 0);

        // third trigger while pending -> dropped
        v0 = vcnt1;
        pulse();
        pulse();
        pulse();
        idle(30);
        chk("ovr_pulses1", vcnt1 - v0, 2);
        chk("ovr_set1", int'(ovr1), 1);
        chk("ovr_set2", int'(ovr2), 1);

        // asynchronous reset mid-pass
        load(100, 200, 300, 400);
        v0 = vcnt1;
        @(negedge clk) done_i = 1'b1;
        @(posedge clk);
        @(negedge clk) done_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy1", int'(busy1), 0);
        chk("arst_addr1", int'(addr1), 0);
        chk("arst_avg1",  int'(avg1), 0);
        chk("arst_ovr1",  int'(ovr1), 0);
        chk("arst_busy2", int'(busy2), 0);
        idle(3);
        rst = 1'b1;
        idle(10);
        chk("arst_no_pulse", vcnt1 - v0, 0);
        pulse();
        idle(12);
        chk("refill_avg1", int'(avg1), 250);
        chk("refill_no_pulse", vcnt1 - v0, 0);
        for (int p = 0; p < 3; p++) begin
            pulse();
            idle(12);
        end
        chk("refill_pulse", vcnt1 - v0, 1);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rbuf_avg.md
Name: rbuf_avg

Overview:
- Downstream consumer of rbuf. rbuf pulses done after each write.
- On each done, this block reads the M-word ring region back from the shared BRAM port.
- It sums the M words and emits the moving average on avg, qualified by avg_valid.
- This is the first filter stage after sample capture; the output feeds display/decimation logic.

Parameters:
- M, 4, ring depth in words; power of two, 2..16; must match rbuf M.
- ADDR_SIZE, 5, BRAM address width; 2^ADDR_SIZE >= M.
- DATA_SIZE, 12, sample width (unsigned).
- RD_LAT, 1, clk edges from rd_addr change to rd_data sampled; 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- done_i  in  1  rbuf done; rising edge triggers one averaging pass.
- rd_addr  out  ADDR_SIZE  BRAM read address.
- rd_data  in  DATA_SIZE  BRAM read data.
- avg  out  DATA_SIZE  latest average, held between updates.
- avg_valid  out  1  one-cycle pulse when avg updates.
- busy  out  1  high while a pass is in progress.
- overrun  out  1  sticky; a trigger was dropped.

Behaviour:
- Reset (rst low, async) clears all outputs and state to 0: rd_addr, avg, avg_valid, busy, overrun, accumulator, fill counter, pending flag, done_i history register. State goes to IDLE.
- Trigger: done_i is high at edge E0 and was low at the previous edge. A level held high triggers only once.
- FSM states:
  - IDLE: on trigger go to READ, set rd_addr=0, busy=1.
  - READ: rd_addr steps 0..M-1, one address per cycle. After rd_addr=M-1 go to DRAIN.
  - DRAIN: wait until the last data is captured, then go to OUT.
  - OUT: single cycle; then IDLE, or READ if a trigger is pending.
- Data capture: rd_addr=k is driven after edge E0+k; rd_data is added to the accumulator at edge E0+k+RD_LAT.
- Accumulator: DATA_SIZE+log2(M) bits, cannot overflow, cleared at each pass start.
- Average: avg = acc >> log2(M), truncating, registered at edge E0+M+RD_LAT. avg_valid is high for the cycle following that edge. Latency for M=4, RD_LAT=1: 5 edges.
- busy: high from after E0 until the avg update edge inclusive.
- Warm-up: fill counter counts triggers and saturates at M. avg updates on every pass, but avg_valid pulses only once fill counter = M. With M=4, the 4th trigger gives the first pulse.
- Trigger while busy: latch one pending trigger. It starts in the cycle after OUT, with rd_addr=0 driven after the OUT edge.
- A second trigger while pending is already set: drop it and set overrun=1 (sticky until reset).
- rd_addr holds 0 when idle.
- Reset asserted mid-pass: abort immediately; no avg_valid pulse.

Test Plan:
- Reset, BRAM words 0..3 = 100,200,300,400, four done_i pulses spaced 20 cycles → avg_valid only after the 4th, 5 edges after its trigger; avg=250.
- Words 4095 ×4, warm → avg=4095, no truncation overflow. Words 1,2,2,2 → avg=1 (7>>2).
- done_i held high 10 cycles → exactly one pass; busy high 5 cycles; rd_addr sequence 0,1,2,3 observed.
- Trigger at E0+2 during a pass → second pass starts after OUT, two avg_valid pulses, overrun=0. A third trigger before the second pass starts → overrun=1, still only two pulses.
- rst low at E0+2 → all outputs 0 asynchronously, no avg_valid; next trigger runs cleanly and fill count restarts.
- RD_LAT=2, words 8,8,8,8, warm → avg=8 with avg_valid after edge E0+6.
